// File: rtl/fetch_mem_arbiter_pkg.sv
// Shared types and constants for the fetch/load-store memory arbiter.
package fetch_mem_arbiter_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY_IF = 2'd1,
      ST_BUSY_LS = 2'd2
   } arb_state_e;

   // funct3 access modes (loads and stores share the low encodings)
   typedef enum logic [2:0] {
      FUN3_B  = 3'b000,
      FUN3_H  = 3'b001,
      FUN3_W  = 3'b010,
      FUN3_BU = 3'b100,
      FUN3_HU = 3'b101
   } fun3_e;

   localparam logic [2:0] LW_FUN3          = FUN3_W;
   localparam int         SYS_ADDR_SPACE   = 32;
   localparam int         CACHE_DATA_WIDTH = 32;

endpackage

// File: rtl/fetch_mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals seen by the arbiter.
interface fetch_mem_arbiter_if
   import fetch_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = SYS_ADDR_SPACE,
   parameter int DATA_W = CACHE_DATA_WIDTH
) ();

   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_flush_i;
   logic              if_ack_o;
   logic [DATA_W-1:0] if_inst_o;

   logic              ls_req_i;
   logic              ls_we_i;
   logic [ADDR_W-1:0] ls_addr_i;
   logic [DATA_W-1:0] ls_wdata_i;
   logic [2:0]        ls_mode_i;
   logic              ls_ack_o;
   logic [DATA_W-1:0] ls_rdata_o;

   logic              mem_re_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [2:0]        mem_mode_o;
   logic [DATA_W-1:0] mem_rdata_i;

   // Arbiter side
   modport slave (
      input  if_req_i, if_addr_i, if_flush_i,
      input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_mode_i,
      input  mem_rdata_i,
      output if_ack_o, if_inst_o, ls_ack_o, ls_rdata_o,
      output mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_mode_o
   );

   // Requester / memory side
   modport master (
      output if_req_i, if_addr_i, if_flush_i,
      output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_mode_i,
      output mem_rdata_i,
      input  if_ack_o, if_inst_o, ls_ack_o, ls_rdata_o,
      input  mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_mode_o
   );

endinterface

// File: rtl/fetch_mem_arbiter_mem_lat_counter.sv
// Loadable down-counter with a done flag; tracks remaining memory busy cycles.
module mem_lat_counter #(
   parameter int MAX_CNT = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           load_i,
   input  logic [$clog2(MAX_CNT)+1-1:0]   load_val_i,
   input  logic                           en_i,
   output logic                           done_o
);

   localparam int CNT_W = $clog2(MAX_CNT) + 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Load takes priority; otherwise count down to zero and hold there
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the load/store
// unit. LS has priority unless fetch has been starved for STARVE_MAX grants.
module fetch_mem_arbiter
   import fetch_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = SYS_ADDR_SPACE,
   parameter int DATA_W     = CACHE_DATA_WIDTH,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input logic                clk_i,
   input logic                rst_i,
   fetch_mem_arbiter_if.slave bus
);

   localparam int               CNT_W    = $clog2(MEM_LAT) + 1;
   localparam int               STV_W    = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);
   localparam logic [STV_W-1:0] STV_SAT  = STV_W'(STARVE_MAX);

   arb_state_e        state_q, state_d;
   logic [STV_W-1:0]  starve_q, starve_d;
   logic              flush_pend_q, flush_pend_d;
   logic              re_q, re_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [2:0]        mode_q, mode_d;
   logic              if_ack_q, if_ack_d;
   logic              ls_ack_q, ls_ack_d;
   logic [DATA_W-1:0] if_inst_q, if_inst_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
   logic              grant_ls, grant_if;
   logic              cnt_load;
   logic              lat_done;

   mem_lat_counter #(
      .MAX_CNT (MEM_LAT)
   ) u_lat_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (cnt_load),
      .load_val_i (LAT_LOAD),
      .en_i       (state_q != ST_IDLE),
      .done_o     (lat_done)
   );

   // Arbitration, grant latching, completion capture and ack generation
   always_comb begin
      state_d      = state_q;
      starve_d     = starve_q;
      flush_pend_d = flush_pend_q;
      re_d         = re_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mode_d       = mode_q;
      if_ack_d     = 1'b0;
      ls_ack_d     = 1'b0;
      if_inst_d    = if_inst_q;
      ls_rdata_d   = ls_rdata_q;
      cnt_load     = 1'b0;
      grant_ls     = bus.ls_req_i && (!bus.if_req_i || (starve_q < STV_SAT));
      grant_if     = bus.if_req_i && !bus.if_flush_i && !grant_ls;

      unique case (state_q)
         ST_IDLE: begin
            if (grant_ls) begin
               state_d  = ST_BUSY_LS;
               cnt_load = 1'b1;
               re_d     = !bus.ls_we_i;
               we_d     = bus.ls_we_i;
               addr_d   = bus.ls_addr_i;
               wdata_d  = bus.ls_wdata_i;
               mode_d   = bus.ls_mode_i;
               // Only count grants that actually made a fetch wait
               if (!bus.if_req_i) begin
                  starve_d = '0;
               end else if (starve_q != STV_SAT) begin
                  starve_d = starve_q + 1'b1;
               end
            end else if (grant_if) begin
               state_d      = ST_BUSY_IF;
               cnt_load     = 1'b1;
               re_d         = 1'b1;
               we_d         = 1'b0;
               addr_d       = bus.if_addr_i;
               wdata_d      = '0;
               mode_d       = LW_FUN3;
               starve_d     = '0;
               flush_pend_d = 1'b0;
            end
         end
         ST_BUSY_IF: begin
            if (bus.if_flush_i) begin
               flush_pend_d = 1'b1;
            end
            if (lat_done) begin
               state_d      = ST_IDLE;
               re_d         = 1'b0;
               we_d         = 1'b0;
               flush_pend_d = 1'b0;
               // A redirect seen at any point in the access, including the
               // final cycle, discards the fetched word
               if (!(flush_pend_q || bus.if_flush_i)) begin
                  if_ack_d  = 1'b1;
                  if_inst_d = bus.mem_rdata_i;
               end
            end
         end
         ST_BUSY_LS: begin
            if (lat_done) begin
               state_d  = ST_IDLE;
               re_d     = 1'b0;
               we_d     = 1'b0;
               ls_ack_d = 1'b1;
               if (!we_q) begin
                  ls_rdata_d = bus.mem_rdata_i;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset aborts any access in flight
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         starve_q     <= '0;
         flush_pend_q <= 1'b0;
         re_q         <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mode_q       <= '0;
         if_ack_q     <= 1'b0;
         ls_ack_q     <= 1'b0;
         if_inst_q    <= '0;
         ls_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         starve_q     <= starve_d;
         flush_pend_q <= flush_pend_d;
         re_q         <= re_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mode_q       <= mode_d;
         if_ack_q     <= if_ack_d;
         ls_ack_q     <= ls_ack_d;
         if_inst_q    <= if_inst_d;
         ls_rdata_q   <= ls_rdata_d;
      end
   end

   assign bus.if_ack_o    = if_ack_q;
   assign bus.if_inst_o   = if_inst_q;
   assign bus.ls_ack_o    = ls_ack_q;
   assign bus.ls_rdata_o  = ls_rdata_q;
   assign bus.mem_re_o    = re_q;
   assign bus.mem_we_o    = we_q;
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_wdata_o = wdata_q;
   assign bus.mem_mode_o  = mode_q;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level timing model.
module tb_fetch_mem_arbiter;
   import fetch_mem_arbiter_pkg::*;

   localparam int MEM_LAT    = 2;
   localparam int STARVE_MAX = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   fetch_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  mode;
   } ls_txn_t;

   logic [31:0] ifq[$];
   ls_txn_t     lsq[$];
   int n_cmp = 0, n_bad = 0, cyc = 0, rcnt = 0, n_if_ack = 0, n_ls_ack = 0;
   int m_log[$], d_log[$];
   bit prev_strobe = 0;

   // Reference model: one outstanding transaction with timestamps
   bit          m_busy, m_who_ls, m_we, m_flushed;
   logic [31:0] m_addr, m_wdata;
   logic [2:0]  m_mode;
   int          m_g, m_starve;
   bit          e_if_ack, e_ls_ack;
   logic [31:0] e_inst, e_rdata;

   function automatic logic [31:0] memval(logic [31:0] a);
      if (a == 32'h100) return 32'h00500093;
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   function automatic void model_reset();
      m_busy = 0; m_who_ls = 0; m_we = 0; m_flushed = 0;
      m_addr = 0; m_wdata = 0; m_mode = 0; m_g = 0; m_starve = 0;
      e_if_ack = 0; e_ls_ack = 0; e_inst = 0; e_rdata = 0;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // Advance the model across the coming clock edge using current inputs
   task automatic model_edge();
      e_if_ack = 0;
      e_ls_ack = 0;
      if (rst) begin
         model_reset();
      end else if (m_busy) begin
         if (!m_who_ls && bus.if_flush_i) m_flushed = 1;
         if (cyc + 1 == m_g + MEM_LAT) begin
            m_busy = 0;
            if (m_who_ls) begin
               e_ls_ack = 1;
               if (!m_we) e_rdata = memval(m_addr);
            end else if (!m_flushed) begin
               e_if_ack = 1;
               e_inst   = memval(m_addr);
            end
         end
      end else if (bus.ls_req_i && (!bus.if_req_i || m_starve < STARVE_MAX)) begin
         m_busy = 1; m_who_ls = 1; m_we = bus.ls_we_i;
         m_addr = bus.ls_addr_i; m_wdata = bus.ls_wdata_i; m_mode = bus.ls_mode_i;
         m_g = cyc + 1;
         m_starve = bus.if_req_i ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
         m_log.push_back(1);
      end else if (bus.if_req_i && !bus.if_flush_i) begin
         m_busy = 1; m_who_ls = 0; m_we = 0; m_flushed = 0;
         m_addr = bus.if_addr_i; m_mode = 3'b010;
         m_g = cyc + 1; m_starve = 0;
         m_log.push_back(0);
      end
   endtask

   task automatic check_cycle();
      chk("mem_re", bus.mem_re_o, m_busy && !m_we);
      chk("mem_we", bus.mem_we_o, m_busy && m_we);
      chk("if_ack", bus.if_ack_o, e_if_ack);
      chk("ls_ack", bus.ls_ack_o, e_ls_ack);
      chk("if_inst", bus.if_inst_o, e_inst);
      chk("ls_rdata", bus.ls_rdata_o, e_rdata);
      if (m_busy) begin
         chk("mem_addr", bus.mem_addr_o, m_addr);
         chk("mem_mode", bus.mem_mode_o, m_mode);
         if (m_we) chk("mem_wdata", bus.mem_wdata_o, m_wdata);
      end
      if ((bus.mem_re_o || bus.mem_we_o) && !prev_strobe)
         d_log.push_back((bus.mem_addr_o < 32'h1000) ? 0 : 1);
      prev_strobe = bus.mem_re_o || bus.mem_we_o;
   endtask

   task automatic drive_reqs();
      bus.if_req_i  = (ifq.size() > 0);
      bus.if_addr_i = (ifq.size() > 0) ? ifq[0] : 32'h0;
      bus.ls_req_i  = (lsq.size() > 0);
      if (lsq.size() > 0) begin
         bus.ls_we_i = lsq[0].we; bus.ls_addr_i = lsq[0].addr;
         bus.ls_wdata_i = lsq[0].wdata; bus.ls_mode_i = lsq[0].mode;
      end else begin
         bus.ls_we_i = 0; bus.ls_addr_i = 0; bus.ls_wdata_i = 0; bus.ls_mode_i = 0;
      end
   endtask

   // One clock: model step, edge, check at negedge, environment reaction
   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check_cycle();
      if (bus.mem_re_o || bus.mem_we_o) rcnt++; else rcnt = 0;
      bus.mem_rdata_i = (bus.mem_re_o && rcnt == MEM_LAT) ? memval(bus.mem_addr_o) : $urandom();
      if (bus.if_ack_o) begin n_if_ack++; if (ifq.size() > 0) void'(ifq.pop_front()); end
      if (bus.ls_ack_o) begin n_ls_ack++; if (lsq.size() > 0) void'(lsq.pop_front()); end
      drive_reqs();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1);
   end

   initial begin
      int start, k, a0, re_cnt, we_cnt, ls_at, if_at;
      logic [2:0]  mode_seen;
      logic [31:0] wd_seen;
      ls_txn_t t;
      int exp_grants[6];
      int modes[5];
      exp_grants = '{1, 1, 1, 1, 0, 1};
      modes = '{0, 1, 2, 4, 5};

      rst = 1'b1;
      bus.if_flush_i = 0; bus.mem_rdata_i = 0;
      model_reset();
      drive_reqs();
      @(negedge clk);
      check_cycle();
      rst = 1'b0;

      // T1: IF only
      start = cyc; a0 = n_if_ack; re_cnt = 0; k = 0;
      ifq.push_back(32'h100); drive_reqs();
      while (n_if_ack == a0 && k < 20) begin tick(); k++; if (bus.mem_re_o) re_cnt++; end
      chk("t1_ack_latency", cyc - start, 3);
      chk("t1_re_cycles", re_cnt, 2);
      chk("t1_inst", bus.if_inst_o, 32'h00500093);

      // T2: simultaneous IF and LS load, LS first
      start = cyc; a0 = n_if_ack; ls_at = -1; k = 0;
      ifq.push_back(32'h104);
      t.we = 0; t.addr = 32'h2000; t.wdata = 0; t.mode = 3'b010; lsq.push_back(t);
      drive_reqs();
      while (n_if_ack == a0 && k < 30) begin
         tick(); k++;
         if (bus.ls_ack_o) ls_at = cyc - start;
      end
      if_at = cyc - start;
      chk("t2_ls_ack_cycle", ls_at, 3);
      chk("t2_if_ack_cycle", if_at, 6);

      // T3: store word
      a0 = n_ls_ack; re_cnt = 0; we_cnt = 0; k = 0; mode_seen = 0; wd_seen = 0;
      t.we = 1; t.addr = 32'h2004; t.wdata = 32'hDEADBEEF; t.mode = 3'b010; lsq.push_back(t);
      drive_reqs();
      while (n_ls_ack == a0 && k < 20) begin
         tick(); k++;
         if (bus.mem_re_o) re_cnt++;
         if (bus.mem_we_o) begin we_cnt++; mode_seen = bus.mem_mode_o; wd_seen = bus.mem_wdata_o; end
      end
      repeat (3) tick();
      chk("t3_we_cycles", we_cnt, 2);
      chk("t3_re_cycles", re_cnt, 0);
      chk("t3_mode", mode_seen, 3'b010);
      chk("t3_wdata", wd_seen, 32'hDEADBEEF);
      chk("t3_ls_acks", n_ls_ack - a0, 1);

      // T4: starvation, 5 back-to-back loads with fetch waiting
      m_log.delete(); d_log.delete(); k = 0;
      for (int i = 0; i < 5; i++) begin
         t.we = 0; t.addr = 32'h2000 + 32'(4 * i); t.wdata = 0; t.mode = 3'b010; lsq.push_back(t);
      end
      ifq.push_back(32'h100); drive_reqs();
      while ((lsq.size() > 0 || ifq.size() > 0) && k < 80) begin tick(); k++; end
      chk("t4_dut_grant_count", d_log.size(), 6);
      chk("t4_model_grant_count", m_log.size(), 6);
      for (int i = 0; i < 6; i++) begin
         chk("t4_dut_grant", (i < d_log.size()) ? d_log[i] : -1, exp_grants[i]);
         chk("t4_model_grant", (i < m_log.size()) ? m_log[i] : -1, exp_grants[i]);
      end

      // T5: flush in the 2nd cycle of BUSY_IF
      a0 = n_if_ack; k = 0;
      ifq.push_back(32'h300); drive_reqs();
      while (!bus.mem_re_o && k < 10) begin tick(); k++; end
      tick();
      bus.if_flush_i = 1; void'(ifq.pop_front()); drive_reqs();
      tick();
      bus.if_flush_i = 0;
      repeat (6) tick();
      chk("t5_flushed_acks", n_if_ack - a0, 0);
      chk("t5_inst_kept", bus.if_inst_o, 32'h00500093);
      a0 = n_if_ack; k = 0;
      ifq.push_back(32'h104); drive_reqs();
      while (n_if_ack == a0 && k < 20) begin tick(); k++; end
      chk("t5_next_fetch_acks", n_if_ack - a0, 1);

      // T6: reset in the middle of BUSY_LS
      k = 0;
      t.we = 0; t.addr = 32'h2100; t.wdata = 0; t.mode = 3'b010; lsq.push_back(t);
      drive_reqs();
      while (!bus.mem_re_o && k < 10) begin tick(); k++; end
      #2 rst = 1'b1;
      #1;
      chk("t6_re_async", bus.mem_re_o, 0);
      chk("t6_we_async", bus.mem_we_o, 0);
      chk("t6_ls_ack_async", bus.ls_ack_o, 0);
      chk("t6_if_ack_async", bus.if_ack_o, 0);
      chk("t6_inst_async", bus.if_inst_o, 0);
      chk("t6_rdata_async", bus.ls_rdata_o, 0);
      model_reset();
      ifq.delete(); lsq.delete(); rcnt = 0; prev_strobe = 0;
      drive_reqs();
      repeat (2) tick();
      rst = 1'b0;
      a0 = n_ls_ack;
      repeat (6) tick();
      chk("t6_no_ack_after_reset", n_ls_ack - a0, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (ifq.size() == 0 && $urandom_range(0, 3) == 0) ifq.push_back($urandom());
         if (lsq.size() == 0 && $urandom_range(0, 3) != 0) begin
            t.we = 1'($urandom_range(0, 1));
            t.addr = $urandom(); t.wdata = $urandom();
            t.mode = t.we ? 3'($urandom_range(0, 2)) : 3'(modes[$urandom_range(0, 4)]);
            lsq.push_back(t);
         end
         bus.if_flush_i = ($urandom_range(0, 15) == 0);
         if (bus.if_flush_i && ifq.size() > 0) void'(ifq.pop_front());
         drive_reqs();
         tick();
      end
      bus.if_flush_i = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
